mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction port: accepts one read or write request at a time over a valid/ready handshake, inserts a configurable number of wait states, performs a byte/half/word access on an internal byte array, and returns read data or an error over a second valid/ready handshake. It replaces the zero-wait combinational memory so the control unit can be exercised against realistic latency. Byte order is big-endian (MIPS).

---
 rtl/mem_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the multicycle CPU. It accepts one
//            read/write request over a valid/ready handshake, waits LATENCY
//            cycles, performs a big-endian byte/half/word access on an
//            internal byte array, and returns data/error over a second
//            valid/ready handshake.
// Options  : MEM_RESP_ERR_EN - enables alignment, size and range error
//            checking. When it is undefined, addresses are force-aligned,
//            taken modulo DEPTH, and size 11 behaves as a word access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH   = 256,   // bytes, power of two
    parameter int LATENCY = 2      // wait cycles, 0..15
) (
    input  logic        clk,
    input  logic        reset,     // asynchronous, active low
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] LAT     = 4'(LATENCY);
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] base_q, base_d;
    logic          err_q, err_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [7:0]    mem_q [DEPTH];

    logic          req_err;
    logic [AW-1:0] req_base;

`ifdef MEM_RESP_ERR_EN
    logic [32:0]   req_last;

    // Decode the incoming request: reject bad sizes, misalignment and any byte past the array.
    always_comb begin
        req_last = {1'b0, req_addr}
                 + ((req_size == SZ_WORD) ? 33'd3 : (req_size == SZ_HALF) ? 33'd1 : 33'd0);
        req_err  = (req_size == 2'b11)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || (req_last >= 33'(DEPTH));
        req_base = req_addr[AW-1:0];
    end
`else
    // High address bits are ignored: the array simply wraps.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:AW];

    // Decode the incoming request: force alignment and wrap modulo DEPTH, never error.
    always_comb begin
        req_err  = 1'b0;
        req_base = req_addr[AW-1:0];
        if (req_size == SZ_HALF) begin
            req_base[0] = 1'b0;
        end else if (req_size != SZ_BYTE) begin
            req_base[1:0] = 2'b00;   // word, and size 11 treated as word
        end
    end
`endif

    logic          accept;
    logic          acc_now;
    logic          acc_write;
    logic          acc_err;
    logic [1:0]    acc_size;
    logic [AW-1:0] acc_base;
    logic [31:0]   acc_wdata;

    // With zero latency the access uses the live request; otherwise the captured copy.
    assign accept    = req_valid && req_ready_q;
    assign acc_now   = reset && (((state_q == ST_IDLE) && accept && (LAT == 4'd0))
                              || ((state_q == ST_WAIT) && (cnt_q == 4'd1)));
    assign acc_write = (state_q == ST_IDLE) ? req_write : write_q;
    assign acc_err   = (state_q == ST_IDLE) ? req_err   : err_q;
    assign acc_size  = (state_q == ST_IDLE) ? req_size  : size_q;
    assign acc_base  = (state_q == ST_IDLE) ? req_base  : base_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

    logic [AW-1:0] idx   [4];
    logic [7:0]    rd_b  [4];
    logic [7:0]    mem_wd [4];
    logic [3:0]    mem_we;
    logic [31:0]   acc_rdata;

    // Big-endian lane mapping: lane 0 is the lowest address and the most significant byte.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx[i]    = acc_base + AW'(i);
            rd_b[i]   = mem_q[idx[i]];
            mem_wd[i] = 8'h00;
        end
        mem_we = 4'b0000;
        case (acc_size)
            SZ_HALF: acc_rdata = {16'h0000, rd_b[0], rd_b[1]};
            SZ_BYTE: acc_rdata = {24'h000000, rd_b[0]};
            default: acc_rdata = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
        endcase
        if (acc_now && acc_write && !acc_err) begin
            case (acc_size)
                SZ_HALF: begin
                    mem_we    = 4'b0011;
                    mem_wd[0] = acc_wdata[15:8];
                    mem_wd[1] = acc_wdata[7:0];
                end
                SZ_BYTE: begin
                    mem_we    = 4'b0001;
                    mem_wd[0] = acc_wdata[7:0];
                end
                default: begin
                    mem_we    = 4'b1111;
                    mem_wd[0] = acc_wdata[31:24];
                    mem_wd[1] = acc_wdata[23:16];
                    mem_wd[2] = acc_wdata[15:8];
                    mem_wd[3] = acc_wdata[7:0];
                end
            endcase
        end
    end

    // Byte array; deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) begin
                mem_q[idx[i]] <= mem_wd[i];
            end
        end
    end

    // Next-state and output computation for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        base_d       = base_q;
        err_d        = err_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    size_d  = req_size;
                    base_d  = req_base;
                    err_d   = req_err;
                    wdata_d = req_wdata;
                    cnt_d   = LAT;
                    if (LAT != 4'd0) begin
                        state_d     = ST_WAIT;
                        req_ready_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
        // The access edge always enters RESP and latches the response.
        if (acc_now) begin
            state_d      = ST_RESP;
            req_ready_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_rdata_d = (acc_write || acc_err) ? 32'h0 : acc_rdata;
            resp_err_d   = acc_err;
        end
    end

    // Sequencer and captured-request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            base_q       <= '0;
            err_q        <= 1'b0;
            wdata_q      <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            base_q       <= base_d;
            err_q        <= err_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. Two instances (LATENCY 2
//            and LATENCY 0) are driven with directed and random requests and
//            compared against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT0  = 2;
    localparam int LAT1  = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [1:0]  req_size   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          last_acc  [2];
    int          prev_hold [2];
    logic [7:0]  mdl [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut_l2 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut_l0 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: an access touches n consecutive bytes, most significant first.
    task automatic model(input int d, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd);
        longint unsigned a;
        int              n;
        n = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
        a = addr;
`ifdef MEM_RESP_ERR_EN
        err = (sz == 2'b11) || (a % n != 0) || (a + n > DEPTH);
`else
        err = 1'b0;
        a   = (a - a % n) % DEPTH;
`endif
        rd = 32'h0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (wr) mdl[d][int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
                else    rd = (rd << 8) | 32'(mdl[d][int'(a) + i]);
            end
        end
    endtask

    // One complete request/response. Called and returns just after a falling edge.
    task automatic xact(input int d, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input bit chk_sp,
                        output logic [31:0] got, output logic got_err);
        logic        e_err;
        logic [31:0] e_rd;
        int          edges;
        int          exp_lat;
        exp_lat = (d == 0) ? LAT0 : LAT1;
        for (int i = 0; i < 20 && !req_ready[d]; i++) @(negedge clk);
        check("req_ready_before", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_size[d]   = sz;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        resp_ready[d] = (hold == 0);
        @(posedge clk);
        #1;
        if (chk_sp) check("spacing", 32'(cyc - last_acc[d]), 32'(exp_lat + 2 + prev_hold[d]));
        last_acc[d]  = cyc;
        prev_hold[d] = hold;
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_size[d]  = 2'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        model(d, wr, sz, addr, wd, e_err, e_rd);
        @(negedge clk);
        edges = 0;
        while (!resp_valid[d] && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", 32'(edges), 32'(exp_lat));
        check("resp_rdata", resp_rdata[d], e_rd);
        check("resp_err", 32'(resp_err[d]), 32'(e_err));
        got     = resp_rdata[d];
        got_err = resp_err[d];
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(resp_valid[d]), 32'd1);
            check("hold_rdata", resp_rdata[d], e_rd);
            check("hold_req_ready", 32'(req_ready[d]), 32'd0);
            @(negedge clk);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_valid", 32'(resp_valid[d]), 32'd0);
        check("post_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic        gerr;
        logic [31:0] addr;
        logic [1:0]  sz;
        int          hold;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_size[d]   = 2'b00;
            req_addr[d]   = 32'h0;
            req_wdata[d]  = 32'h0;
            resp_ready[d] = 1'b0;
            last_acc[d]   = 0;
            prev_hold[d]  = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_resp_rdata", resp_rdata[d], 32'h0);
            check("rst_resp_err", 32'(resp_err[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("rst_req_ready", 32'(req_ready[d]), 32'd1);

        // Fill both arrays so every model byte is known.
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < DEPTH; a += 4)
                xact(d, 1'b1, 2'b00, 32'(a), $urandom, 0, 1'b0, got, gerr);

        // Directed big-endian sequence on the LATENCY=2 instance.
        xact(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 1'b0, got, gerr);
        check("tp_write_rdata", got, 32'h0);
        xact(0, 1'b0, 2'b00, 32'h10, 32'h0, 0, 1'b1, got, gerr);
        check("tp_read_word", got, 32'hDEADBEEF);
        xact(0, 1'b0, 2'b10, 32'h11, 32'h0, 0, 1'b1, got, gerr);
        check("tp_read_byte", got, 32'h000000AD);
        xact(0, 1'b0, 2'b01, 32'h12, 32'h0, 0, 1'b1, got, gerr);
        check("tp_read_half", got, 32'h0000BEEF);
        xact(0, 1'b1, 2'b10, 32'h13, 32'hFFFFFF55, 0, 1'b1, got, gerr);
        xact(0, 1'b0, 2'b00, 32'h10, 32'h0, 0, 1'b1, got, gerr);
        check("tp_read_merged", got, 32'hDEADBE55);

        // Error-prone requests; the model predicts either errors or wrap/align behaviour.
        xact(0, 1'b0, 2'b00, 32'h12, 32'h0, 0, 1'b1, got, gerr);
`ifdef MEM_RESP_ERR_EN
        check("tp_misalign_err", 32'(gerr), 32'd1);
        check("tp_misalign_rdata", got, 32'h0);
`endif
        xact(0, 1'b1, 2'b00, 32'h100, 32'hA5A5A5A5, 0, 1'b1, got, gerr);
        xact(0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 1'b1, got, gerr);
        xact(0, 1'b0, 2'b11, 32'h10, 32'h0, 0, 1'b1, got, gerr);
        xact(0, 1'b0, 2'b00, 32'h10, 32'h0, 0, 1'b1, got, gerr);

        // Response held off for five cycles.
        xact(0, 1'b0, 2'b00, 32'h10, 32'h0, 5, 1'b1, got, gerr);

        // Reset while a word write is still waiting: the write must be dropped.
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b1;
        req_size[0]   = 2'b00;
        req_addr[0]   = 32'h20;
        req_wdata[0]  = 32'h12345678;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("wait_req_ready", 32'(req_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
        check("mid_rst_rdata", resp_rdata[0], 32'h0);
        check("mid_rst_err", 32'(resp_err[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ready", 32'(req_ready[0]), 32'd1);
        xact(0, 1'b0, 2'b00, 32'h20, 32'h0, 0, 1'b0, got, gerr);

        // Random traffic on both instances, with spacing checks between consecutive requests.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 150; k++) begin
                addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
                sz   = 2'($urandom_range(0, 3));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                xact(d, 1'($urandom_range(0, 1)), sz, addr, $urandom, hold, k > 0, got, gerr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
